// File: rtl/chu_edge_capture_core.sv
`default_nettype none
// ============================================================================
// chu_edge_capture_core - timestamps cap_in edges into a FIFO (MMIO slot 4)
// Revision 1.0
// ============================================================================
module chu_edge_capture_core #(
  parameter int FIFO_DEPTH_BIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        read,
  input  logic        write,
  input  logic [4:0]  addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  input  logic        cap_in
);

  localparam int DEPTH = 1 << FIFO_DEPTH_BIT;
  localparam logic [FIFO_DEPTH_BIT:0]   FULL_COUNT = {1'b1, {FIFO_DEPTH_BIT{1'b0}}};
  localparam logic [FIFO_DEPTH_BIT:0]   CNT_ONE    = {{FIFO_DEPTH_BIT{1'b0}}, 1'b1};
  localparam logic [FIFO_DEPTH_BIT-1:0] PTR_ONE    = {{(FIFO_DEPTH_BIT-1){1'b0}}, 1'b1};

  logic                      s1, s2, s3;
  logic [30:0]               tick;
  logic [2:0]                ctrl;
  logic [31:0]               mem [DEPTH];
  logic [FIFO_DEPTH_BIT-1:0] wr_ptr, rd_ptr;
  logic [FIFO_DEPTH_BIT:0]   count;
  logic                      overflow;

  logic wr_en, ctrl_wr, pop_req, clr;
  logic en, rise_en, fall_en;
  logic rise, fall, push_req;
  logic full, empty, do_pop, do_push;
  logic unused_ok;

  assign wr_en   = cs & write;
  assign ctrl_wr = wr_en && (addr == 5'd2);
  assign pop_req = wr_en && (addr == 5'd3);
  assign clr     = wr_en && (addr == 5'd4);

  assign en      = ctrl[0];
  assign rise_en = ctrl[1];
  assign fall_en = ctrl[2];

  assign rise     = s2 & ~s3;
  assign fall     = ~s2 & s3;
  assign push_req = en & ((rise & rise_en) | (fall & fall_en));

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);

  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign do_pop  = pop_req & ~empty;
  assign do_push = push_req & (~full | do_pop);

  // Reads have no side effects and only the low ctrl bits are stored.
  assign unused_ok = ^{read, wr_data[31:3]};

  always_ff @(posedge clk) begin
    if (reset) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      s3       <= 1'b0;
      tick     <= '0;
      ctrl     <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      s1 <= cap_in;
      s2 <= s1;
      s3 <= s2;
      if (ctrl_wr)
        ctrl <= wr_data[2:0];
      if (clr) begin
        tick     <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        overflow <= 1'b0;
      end else begin
        if (en)
          tick <= tick + 31'd1;
        if (do_push)
          wr_ptr <= wr_ptr + PTR_ONE;
        if (do_pop)
          rd_ptr <= rd_ptr + PTR_ONE;
        if (do_push && !do_pop)
          count <= count + CNT_ONE;
        else if (do_pop && !do_push)
          count <= count - CNT_ONE;
        if (push_req && !do_push)
          overflow <= 1'b1;
      end
    end
  end

  // Storage needs no reset: the head is masked to 0 whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push && !clr && !reset)
      mem[wr_ptr] <= {rise, tick};
  end

  always_comb begin
    rd_data = '0;
    case (addr)
      5'd0: begin
        rd_data[0]                  = empty;
        rd_data[1]                  = full;
        rd_data[FIFO_DEPTH_BIT+2:2] = count;
        rd_data[FIFO_DEPTH_BIT+3]   = overflow;
      end
      5'd1:    rd_data = empty ? 32'd0 : mem[rd_ptr];
      5'd2:    rd_data = {29'd0, ctrl};
      5'd5:    rd_data = {1'b0, tick};
      default: rd_data = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_chu_edge_capture_core.sv
`default_nettype none
// Scoreboarded bench for chu_edge_capture_core: directed boundary cases then random traffic.
module tb_chu_edge_capture_core;

  localparam int FDB   = 4;
  localparam int DEPTH = 1 << FDB;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cs = 1'b0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [4:0]  addr = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_data;
  logic        cap_in = 1'b0;

  chu_edge_capture_core #(.FIFO_DEPTH_BIT(FDB)) dut (
    .clk     (clk),
    .reset   (reset),
    .cs      (cs),
    .read    (read),
    .write   (write),
    .addr    (addr),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .cap_in  (cap_in)
  );

  always #5 clk = ~clk;

  // Reference model: queue of captured entries plus a cap_in sample history.
  logic [31:0] m_q[$];
  logic [30:0] m_tick;
  logic [2:0]  m_ctrl;
  logic        m_ovf;
  logic [2:0]  m_hist;  // [0] newest sample of cap_in

  typedef struct {
    logic [4:0]  a;
    logic [31:0] v;
  } exp_t;
  exp_t expq[$];

  int n_total = 0;
  int n_pass  = 0;

  task automatic model_step();
    logic rise, fall, wr, push;
    if (reset) begin
      m_q.delete();
      m_tick = '0;
      m_ctrl = '0;
      m_ovf  = 1'b0;
      m_hist = '0;
    end else begin
      // An edge is seen once the new level has crossed two synchronizer stages.
      rise = m_hist[1] & ~m_hist[2];
      fall = ~m_hist[1] & m_hist[2];
      wr   = cs & write;
      push = m_ctrl[0] & ((rise & m_ctrl[1]) | (fall & m_ctrl[2]));
      if (wr && addr == 5'd4) begin
        m_q.delete();
        m_ovf  = 1'b0;
        m_tick = '0;
      end else begin
        if (wr && addr == 5'd3 && m_q.size() > 0)
          void'(m_q.pop_front());
        if (push) begin
          if (m_q.size() < DEPTH) m_q.push_back({rise, m_tick});
          else m_ovf = 1'b1;
        end
        if (m_ctrl[0]) m_tick = m_tick + 31'd1;
      end
      if (wr && addr == 5'd2) m_ctrl = wr_data[2:0];
      m_hist = {m_hist[1:0], cap_in};
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    logic [31:0] r;
    r = '0;
    case (a)
      5'd0: begin
        r[0]         = (m_q.size() == 0);
        r[1]         = (m_q.size() == DEPTH);
        r[FDB+2:2]   = (FDB+1)'(m_q.size());
        r[FDB+3]     = m_ovf;
      end
      5'd1:    r = (m_q.size() == 0) ? 32'd0 : m_q[0];
      5'd2:    r = {29'd0, m_ctrl};
      5'd5:    r = {1'b0, m_tick};
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    cs    = 1'b0;
    read  = 1'b0;
    write = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
    step();
  endtask

  task automatic rd(input logic [4:0] a);
    exp_t e;
    cs = 1'b1; read = 1'b1; addr = a;
    e.a = a;
    e.v = model_read(a);
    expq.push_back(e);
    step();
  endtask

  task automatic toggle_and_wait(input int n);
    cap_in = ~cap_in;
    idle(n);
  endtask

  // Toggle cap_in so that its push lands on the edge that also samples the next bus op.
  task automatic toggle_aligned();
    cap_in = ~cap_in;
    idle(2);
  endtask

  // Monitor: compares every presented read against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (cs && read) begin
        n_total++;
        if (expq.size() == 0) begin
          $display("FAIL scoreboard_underflow addr=%0d got=%08h required=<none>", addr, rd_data);
        end else begin
          e = expq.pop_front();
          if (rd_data === e.v) n_pass++;
          else $display("FAIL read_addr%0d got=%08h required=%08h", e.a, rd_data, e.v);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    m_tick = '0; m_ctrl = '0; m_ovf = 1'b0; m_hist = '0;
    reset = 1'b1;
    idle(2);
    reset = 1'b0;

    // Reset state
    rd(5'd0); rd(5'd1); rd(5'd2); rd(5'd5);

    // Single rising capture, then pop
    wr(5'd2, 32'h3);
    idle(10);
    toggle_and_wait(4);
    rd(5'd0); rd(5'd1); rd(5'd5);
    wr(5'd3, 32'hFFFF_FFFF);
    rd(5'd0);

    // Falling-only capture
    wr(5'd2, 32'h0);
    cap_in = 1'b0;
    idle(4);
    wr(5'd2, 32'h5);
    toggle_and_wait(20);
    toggle_and_wait(5);
    rd(5'd0); rd(5'd1); rd(5'd2);
    wr(5'd3, 32'h0);

    // Overflow with 17 edges, drain, then clear
    wr(5'd2, 32'h7);
    for (int i = 0; i < DEPTH + 1; i++) toggle_and_wait(3);
    rd(5'd0);
    for (int i = 0; i < DEPTH; i++) begin
      rd(5'd1);
      wr(5'd3, 32'h0);
    end
    rd(5'd0); rd(5'd1);
    wr(5'd4, 32'h0);
    rd(5'd0); rd(5'd5);

    // Same-cycle push/pop with three entries
    for (int i = 0; i < 3; i++) toggle_and_wait(3);
    rd(5'd0);
    toggle_aligned();
    wr(5'd3, 32'h0);
    idle(2);
    rd(5'd0); rd(5'd1);
    // Clear coinciding with a push
    toggle_aligned();
    wr(5'd4, 32'h0);
    idle(3);
    rd(5'd0);
    // Pop on empty
    wr(5'd3, 32'h0);
    rd(5'd0);
    // Push and pop together on an empty FIFO
    toggle_aligned();
    wr(5'd3, 32'h0);
    idle(2);
    rd(5'd0); rd(5'd1);

    // Push and pop together on a full FIFO
    wr(5'd4, 32'h0);
    for (int i = 0; i < DEPTH; i++) toggle_and_wait(3);
    rd(5'd0);
    toggle_aligned();
    wr(5'd3, 32'h0);
    idle(2);
    rd(5'd0); rd(5'd1);

    // Disabled capture keeps contents poppable
    wr(5'd2, 32'h6);
    toggle_and_wait(4);
    toggle_and_wait(4);
    rd(5'd0); rd(5'd5);
    wr(5'd3, 32'h0);
    rd(5'd0); rd(5'd1);

    // Reset mid-stream drops partially synchronized edges
    wr(5'd2, 32'h7);
    cap_in = ~cap_in;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    idle(3);
    rd(5'd0); rd(5'd1); rd(5'd2); rd(5'd5);

    // Randomized traffic
    wr(5'd2, 32'h7);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) cap_in = ~cap_in;
      case ($urandom_range(0, 11))
        0, 1: wr(5'd3, $urandom);
        2: if ($urandom_range(0, 5) == 0) wr(5'd4, $urandom); else step();
        3: begin
          d = $urandom;
          if ($urandom_range(0, 3) != 0) d[0] = 1'b1;
          wr(5'd2, d);
        end
        4: begin
          cs = 1'b0; write = 1'b1;
          addr = 5'($urandom_range(2, 4));
          wr_data = $urandom;
          step();
        end
        5: step();
        default: rd(5'($urandom_range(0, 7)));
      endcase
    end

    idle(3);
    if (expq.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard_drain got=%0d pending required=0", expq.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
